seat_timer: RTL and testbench

Parametrised time-of-day timer with multi-channel reservation expiry for the seating controller. Divides the system clock into minute ticks, keeps a settable 24-hour hour/minute count, and holds N_CH independently armed target times. Each channel emits a one-cycle expiry pulse when the clock reaches its target, so seat reservations can be released. Outputs the packed current time for display and logging.

---
 rtl/seat_timer_if.sv | 33 +++
 rtl/seat_timer.sv | 117 +++++++++++
 tb/tb_seat_timer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seat_timer_if.sv
// Bundles the seat_timer request inputs and time/expiry outputs.
// master drives requests (controller or bench); slave is the timer itself.
interface seat_timer_if #(
    parameter int N_CH = 8,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic            run;
    logic            set_en;
    logic [4:0]      set_hour;
    logic [5:0]      set_min;
    logic            ch_arm;
    logic            ch_clr;
    logic [CH_W-1:0] ch_sel;
    logic [4:0]      ch_hour;
    logic [5:0]      ch_min;
    logic [4:0]      hour;
    logic [5:0]      minute;
    logic [10:0]     time_out;
    logic            min_tick;
    logic [N_CH-1:0] expire;
    logic [N_CH-1:0] armed;
    logic            cfg_err;

    modport master (
        output run, set_en, set_hour, set_min, ch_arm, ch_clr, ch_sel, ch_hour, ch_min,
        input  hour, minute, time_out, min_tick, expire, armed, cfg_err
    );

    modport slave (
        input  run, set_en, set_hour, set_min, ch_arm, ch_clr, ch_sel, ch_hour, ch_min,
        output hour, minute, time_out, min_tick, expire, armed, cfg_err
    );
endinterface

// File: rtl/seat_timer.sv
// Time-of-day timer: minute prescaler, settable 24 h clock and N_CH armed
// target times that pulse expire when the clock advances onto them.
module seat_timer #(
    parameter longint unsigned TICKS_PER_MIN = 64'd50_000_000 * 64'd60,
    parameter int              N_CH          = 8,
    parameter int              CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic        clk,
    input  logic        rst,
    seat_timer_if.slave bus
);
    localparam int          PW       = $clog2(TICKS_PER_MIN);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MIN - 64'd1);

    logic [PW-1:0]   pre_q;
    logic [4:0]      hour_q;
    logic [5:0]      min_q;
    logic [10:0]     tgt_q [N_CH];
    logic [N_CH-1:0] armed_q;
    logic [N_CH-1:0] expire_q;
    logic            tick_q;
    logic            err_q;

    logic            set_ok;
    logic            sel_ok;
    logic            tgt_ok;
    logic            arm_bad;
    logic            advance;
    logic [4:0]      next_hour;
    logic [5:0]      next_min;
    logic [N_CH-1:0] touch;
    logic [N_CH-1:0] hit;

    // Request decode, next time-of-day and per-channel match for this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        touch     = '0;
        hit       = '0;
        next_hour = hour_q;
        next_min  = min_q + 6'd1;
        set_ok    = bus.set_en && (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59);
        sel_ok    = int'(bus.ch_sel) < N_CH;
        tgt_ok    = (bus.ch_hour <= 5'd23) && (bus.ch_min <= 6'd59);
        arm_bad   = bus.ch_arm && !(sel_ok && tgt_ok);
        // A valid load owns the cycle: the pending minute advance is dropped.
        advance   = bus.run && (pre_q == PRE_LAST) && !set_ok;

        if (min_q == 6'd59) begin
            next_min  = 6'd0;
            next_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end

        for (int i = 0; i < N_CH; i++) begin
            // An effective clear or arm on a channel overrides its expiry.
            touch[i] = sel_ok && (bus.ch_sel == CH_W'(i)) &&
                       (bus.ch_clr || (bus.ch_arm && tgt_ok));
            hit[i]   = advance && armed_q[i] && !touch[i] &&
                       (tgt_q[i] == {next_hour, next_min});
        end
    end

    // Prescaler, time registers, channel table and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            armed_q  <= '0;
            expire_q <= '0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
            // NOTE: the target table is small and must read as zero after reset, so it is reset explicitly.
            for (int i = 0; i < N_CH; i++) begin
                tgt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            tick_q   <= advance;
            expire_q <= hit;
            err_q    <= (bus.set_en && !set_ok) || arm_bad;

            if (set_ok) begin
                pre_q  <= '0;
                hour_q <= bus.set_hour;
                min_q  <= bus.set_min;
            end else if (bus.run) begin
                pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                if (advance) begin
                    hour_q <= next_hour;
                    min_q  <= next_min;
                end
            end

            for (int i = 0; i < N_CH; i++) begin
                if (touch[i]) begin
                    if (bus.ch_clr) begin
                        armed_q[i] <= 1'b0;
                    end else begin
                        armed_q[i] <= 1'b1;
                        tgt_q[i]   <= {bus.ch_hour, bus.ch_min};
                    end
                end else if (hit[i]) begin
                    armed_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.hour     = hour_q;
    assign bus.minute   = min_q;
    assign bus.time_out = {hour_q, min_q};
    assign bus.min_tick = tick_q;
    assign bus.expire   = expire_q;
    assign bus.armed    = armed_q;
    assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_seat_timer.sv
// Bench for seat_timer: directed scenarios followed by random traffic, all
// checked every cycle against a minutes-of-day reference model.
module tb_seat_timer;
    localparam int TICKS = 4;
    localparam int NCH   = 4;
    localparam int DAY   = 24 * 60;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seat_timer_if #(.N_CH(NCH), .CH_W(2)) bus ();

    seat_timer #(.TICKS_PER_MIN(TICKS), .N_CH(NCH), .CH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: time as minutes since midnight, targets likewise.
    int       m_tod;
    int       m_pre;
    bit [3:0] m_armed;
    int       m_tgt [NCH];
    bit       e_tick;
    bit [3:0] e_exp;
    bit       e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit set_ok, sel_ok, arm_valid, adv, req;
        e_tick = 1'b0;
        e_exp  = '0;
        e_err  = 1'b0;
        if (rst) begin
            m_tod   = 0;
            m_pre   = 0;
            m_armed = '0;
            for (int i = 0; i < NCH; i++) m_tgt[i] = 0;
            return;
        end
        set_ok    = bus.set_en && bus.set_hour < 24 && bus.set_min < 60;
        sel_ok    = int'(bus.ch_sel) < NCH;
        arm_valid = sel_ok && bus.ch_hour < 24 && bus.ch_min < 60;
        e_err     = (bus.set_en && !set_ok) || (bus.ch_arm && !arm_valid);
        adv       = 1'b0;
        if (set_ok) begin
            m_tod = int'(bus.set_hour) * 60 + int'(bus.set_min);
            m_pre = 0;
        end else if (bus.run) begin
            if (m_pre == TICKS - 1) begin
                m_pre  = 0;
                m_tod  = (m_tod + 1) % DAY;
                adv    = 1'b1;
                e_tick = 1'b1;
            end else begin
                m_pre++;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            req = sel_ok && int'(bus.ch_sel) == i && (bus.ch_clr || (bus.ch_arm && arm_valid));
            if (req) begin
                if (bus.ch_clr) m_armed[i] = 1'b0;
                else begin
                    m_armed[i] = 1'b1;
                    m_tgt[i]   = int'(bus.ch_hour) * 60 + int'(bus.ch_min);
                end
            end else if (adv && m_armed[i] && m_tgt[i] == m_tod) begin
                e_exp[i]   = 1'b1;
                m_armed[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".hour"},     32'(bus.hour),     32'(m_tod / 60));
        chk({tag, ".minute"},   32'(bus.minute),   32'(m_tod % 60));
        chk({tag, ".time_out"}, 32'(bus.time_out), 32'({5'(m_tod / 60), 6'(m_tod % 60)}));
        chk({tag, ".min_tick"}, 32'(bus.min_tick), 32'(e_tick));
        chk({tag, ".expire"},   32'(bus.expire),   32'(e_exp));
        chk({tag, ".armed"},    32'(bus.armed),    32'(m_armed));
        chk({tag, ".cfg_err"},  32'(bus.cfg_err),  32'(e_err));
    endtask

    // One clock: model, edge, sample 1 time unit later, compare, drop pulses.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
        bus.set_en = 1'b0;
        bus.ch_arm = 1'b0;
        bus.ch_clr = 1'b0;
    endtask

    task automatic do_set(input int h, input int m);
        bus.set_en   = 1'b1;
        bus.set_hour = 5'(h);
        bus.set_min  = 6'(m);
        cycle("set");
    endtask

    task automatic do_arm(input int ch, input int h, input int m);
        bus.ch_arm  = 1'b1;
        bus.ch_sel  = 2'(ch);
        bus.ch_hour = 5'(h);
        bus.ch_min  = 6'(m);
        cycle("arm");
    endtask

    initial begin
        int ticks_seen;
        int exp_cycles;
        int ch1_fired;

        bus.run = 1'b1;
        bus.set_en = 1'b0; bus.set_hour = '0; bus.set_min = '0;
        bus.ch_arm = 1'b0; bus.ch_clr = 1'b0; bus.ch_sel = '0;
        bus.ch_hour = '0;  bus.ch_min = '0;

        // Reset, then the first minute advance after TICKS cycles.
        rst = 1'b1;
        cycle("reset");
        chk("reset.time_out", 32'(bus.time_out), 32'd0);
        rst = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < TICKS; i++) begin
            cycle("first_min");
            ticks_seen += int'(bus.min_tick);
        end
        chk("first_min.minute", 32'(bus.minute), 32'd1);
        chk("first_min.time_out", 32'(bus.time_out), 32'(11'b00000_000001));
        chk("first_min.ticks", 32'(ticks_seen), 32'd1);

        // Midnight rollover.
        do_set(23, 59);
        for (int i = 0; i < TICKS; i++) cycle("rollover");
        chk("rollover.hour", 32'(bus.hour), 32'd0);
        chk("rollover.minute", 32'(bus.minute), 32'd0);
        chk("rollover.tick", 32'(bus.min_tick), 32'd1);

        // Two channels expiring together.
        do_set(10, 0);
        do_arm(0, 10, 2);
        do_arm(3, 10, 2);
        exp_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("dual_expire");
            if (bus.expire === 4'b1001) exp_cycles++;
        end
        chk("dual_expire.pulses", 32'(exp_cycles), 32'd1);
        chk("dual_expire.armed", 32'(bus.armed), 32'd0);

        // Arming the current time does not fire.
        do_set(10, 5);
        do_arm(1, 10, 5);
        ch1_fired = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("arm_now");
            ch1_fired += int'(bus.expire[1]);
        end
        chk("arm_now.fired", 32'(ch1_fired), 32'd0);
        chk("arm_now.armed1", 32'(bus.armed[1]), 32'd1);

        // Rejected set and arm requests.
        bus.run = 1'b0;
        do_set(24, 0);
        chk("bad_set.cfg_err", 32'(bus.cfg_err), 32'd1);
        do_arm(0, 10, 60);
        chk("bad_arm.cfg_err", 32'(bus.cfg_err), 32'd1);
        chk("bad_arm.armed0", 32'(bus.armed[0]), 32'd0);
        cycle("err_idle");
        chk("err_idle.cfg_err", 32'(bus.cfg_err), 32'd0);
        bus.run = 1'b1;

        // Clear in the advance cycle beats expiry; ch1 (10:05) still fires.
        do_set(10, 4);
        do_arm(2, 10, 5);
        cycle("pre_adv");
        cycle("pre_adv");
        bus.ch_clr = 1'b1;
        bus.ch_sel = 2'd2;
        cycle("clr_race");
        chk("clr_race.minute", 32'(bus.minute), 32'd5);
        chk("clr_race.expire", 32'(bus.expire), 32'(4'b0010));
        chk("clr_race.armed2", 32'(bus.armed[2]), 32'd0);

        // Load in the advance cycle beats the minute advance.
        do_set(10, 4);
        do_arm(2, 10, 5);
        cycle("pre_adv2");
        cycle("pre_adv2");
        bus.set_en = 1'b1; bus.set_hour = 5'd12; bus.set_min = 6'd30;
        cycle("set_race");
        chk("set_race.hour", 32'(bus.hour), 32'd12);
        chk("set_race.minute", 32'(bus.minute), 32'd30);
        chk("set_race.tick", 32'(bus.min_tick), 32'd0);
        chk("set_race.expire", 32'(bus.expire), 32'd0);
        chk("set_race.armed2", 32'(bus.armed[2]), 32'd1);

        // Random traffic; targets cluster just ahead of the model's time.
        for (int n = 0; n < 600; n++) begin
            int off;
            rst     = ($urandom_range(0, 249) == 0);
            bus.run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                bus.set_en   = 1'b1;
                bus.set_hour = 5'($urandom_range(0, 25));
                bus.set_min  = 6'($urandom_range(0, 62));
            end
            if ($urandom_range(0, 4) == 0) begin
                off = (m_tod + int'($urandom_range(0, 3))) % DAY;
                bus.ch_arm  = 1'b1;
                bus.ch_sel  = 2'($urandom_range(0, NCH - 1));
                bus.ch_hour = 5'(off / 60);
                bus.ch_min  = ($urandom_range(0, 15) == 0) ? 6'd61 : 6'(off % 60);
            end
            if ($urandom_range(0, 14) == 0) begin
                bus.ch_clr = 1'b1;
                bus.ch_sel = 2'($urandom_range(0, NCH - 1));
            end
            cycle("random");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
